// File: rtl/sha2inctrl.sv
// sha2inctrl: sequences datapath strobes to assemble SHA-256 padded 512-bit blocks from 64-bit packets
module sha2inctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       msg_vld,
  input  logic       msg_last,
  output logic       msg_rdy,
  input  logic [2:0] idx,
  output logic       clr,
  output logic       st_pkt,
  output logic       pad_pkt,
  output logic       zero_pkt,
  output logic       mgln_pkt,
  output logic       blk_vld,
  output logic       blk_last,
  input  logic       blk_ack,
  output logic       msg_done
);
  typedef enum logic [2:0] {IDLE, DATA, PAD, ZERO, LEN, WAIT} state_t;
  state_t state, ret;
  logic fin, done;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      ret   <= DATA;
      fin   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          state <= DATA;
          fin   <= 1'b0;
        end
        DATA: if (msg_vld) begin
          if (idx == 3'd7) begin
            state <= WAIT;
            ret   <= msg_last ? PAD : DATA;
          end else if (msg_last) state <= PAD;
        end
        PAD: if (idx == 3'd7) begin
          state <= WAIT;
          ret   <= ZERO;
        end else state <= (idx == 3'd6) ? LEN : ZERO;
        ZERO: if (idx == 3'd6) state <= LEN;
        LEN: begin
          state <= WAIT;
          fin   <= 1'b1;
        end
        WAIT: if (blk_ack) begin
          state <= fin ? IDLE : ret;
          done  <= fin;
        end
        default: state <= IDLE;
      endcase
    end
  // every output is forced low while reset is held, clr included
  always_comb begin
    clr      = ~rst & (state == IDLE);
    msg_rdy  = ~rst & (state == DATA);
    pad_pkt  = ~rst & (state == PAD);
    zero_pkt = ~rst & (state == ZERO);
    mgln_pkt = ~rst & (state == LEN);
    st_pkt   = (msg_rdy & msg_vld) | pad_pkt | zero_pkt | mgln_pkt;
    blk_vld  = ~rst & (state == WAIT);
    blk_last = blk_vld & fin;
    msg_done = ~rst & done;
  end
endmodule

// File: tb/tb_sha2inctrl.sv
// tb_sha2inctrl: drives random messages through sha2inctrl plus a datapath model and checks padded blocks
module tb_sha2inctrl;
  logic clk = 1'b0, rst = 1'b1, msg_vld = 1'b0, msg_last = 1'b0, blk_ack = 1'b0;
  logic [2:0] idx = 3'd0;
  logic msg_rdy, clr, st_pkt, pad_pkt, zero_pkt, mgln_pkt, blk_vld, blk_last, msg_done;
  logic [63:0] pkt = 64'd0, len = 64'd0;
  logic [63:0] blk [8];
  logic [8:0] outs;
  int checks = 0, errors = 0;

  sha2inctrl dut (
    .clk(clk), .rst(rst), .msg_vld(msg_vld), .msg_last(msg_last), .msg_rdy(msg_rdy),
    .idx(idx), .clr(clr), .st_pkt(st_pkt), .pad_pkt(pad_pkt), .zero_pkt(zero_pkt),
    .mgln_pkt(mgln_pkt), .blk_vld(blk_vld), .blk_last(blk_last), .blk_ack(blk_ack),
    .msg_done(msg_done)
  );

  assign outs = {msg_rdy, clr, st_pkt, pad_pkt, zero_pkt, mgln_pkt, blk_vld, blk_last, msg_done};

  always #5 clk = ~clk;

  // datapath: slot counter, block store and bit-length register
  always @(posedge clk)
    if (clr) begin
      idx <= 3'd0;
      len <= 64'd0;
    end else if (st_pkt) begin
      blk[idx] <= pad_pkt ? 64'h8000_0000_0000_0000 : zero_pkt ? 64'd0 : mgln_pkt ? len : pkt;
      idx <= idx + 3'd1;
      if (!(pad_pkt | zero_pkt | mgln_pkt)) len <= len + 64'd64;
    end

  function automatic logic [511:0] blkval();
    logic [511:0] r;
    for (int i = 0; i < 8; i++) r[511-64*i -: 64] = blk[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // standard SHA-256 padding of n 64-bit words, checked block by block
  task automatic run_msg(input int n, input int gap, input int ackd);
    logic [63:0] w[$];
    logic [511:0] e;
    int p = 0, b = 0, nb, wc = 0, cyc = 0;
    bit fin = 0, hold = 0;
    for (int i = 0; i < n; i++) w.push_back({$urandom, $urandom});
    w.push_back(64'h8000_0000_0000_0000);
    while (w.size() % 8 != 7) w.push_back(64'd0);
    w.push_back(64'(64 * n));
    nb = w.size() / 8;
    while (!fin && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      msg_vld = (p < n) && (gap == 0 || $urandom_range(0, gap) == 0);
      pkt = msg_vld ? w[p] : {$urandom, $urandom};
      msg_last = msg_vld ? (p == n - 1) : 1'($urandom);
      blk_ack = 1'b0;
      #1;
      chk("msg_done_early", msg_done, 0);
      if (msg_rdy) chk("data_store", {st_pkt, pad_pkt, zero_pkt, mgln_pkt}, {msg_vld, 3'b000});
      else begin
        chk("sel_onehot", $countones({pad_pkt, zero_pkt, mgln_pkt}) <= 1, 1);
        chk("st_sel", st_pkt, pad_pkt | zero_pkt | mgln_pkt);
      end
      if (hold) chk("blk_hold", blk_vld, 1);
      if (blk_vld) begin
        e = '0;
        for (int i = 0; i < 8; i++) e[511-64*i -: 64] = w[b*8+i];
        chk("blk_data", blkval(), e);
        chk("blk_last", blk_last, b == nb - 1);
        chk("wait_quiet", {msg_rdy, st_pkt}, 0);
        blk_ack = wc >= ackd;
        wc++;
        hold = !blk_ack;
        if (blk_ack) begin
          b++;
          wc = 0;
          fin = (b == nb);
        end
      end else begin
        hold = 0;
        blk_ack = $urandom_range(0, 3) == 0;
      end
      if (msg_vld && msg_rdy) p++;
    end
    chk("msg_complete", {p == n, fin}, 2'b11);
    @(negedge clk);
    msg_vld = 1'b0;
    msg_last = 1'b0;
    blk_ack = 1'b0;
    #1;
    chk("done_pulse", {msg_done, clr, blk_vld, msg_rdy}, 4'b1100);
    @(negedge clk);
    #1;
    chk("rdy_again", {msg_rdy, msg_done, clr}, 3'b100);
  endtask

  initial begin
    msg_vld = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_outs0", outs, 0);
    @(negedge clk);
    #1;
    chk("rst_outs1", outs, 0);
    rst = 1'b0;
    msg_vld = 1'b0;
    #1;
    chk("first_clr", {clr, msg_rdy}, 2'b10);
    @(negedge clk);
    #1;
    chk("first_rdy", {clr, msg_rdy}, 2'b01);
    run_msg(1, 0, 0);
    run_msg(6, 0, 1);
    run_msg(7, 0, 2);
    run_msg(8, 0, 0);
    run_msg(11, 3, 5);
    for (int k = 0; k < 4; k++) run_msg($urandom_range(1, 20), $urandom_range(0, 3), $urandom_range(0, 6));
    @(negedge clk);
    msg_vld = 1'b1;
    msg_last = 1'b1;
    pkt = {$urandom, $urandom};
    @(negedge clk);
    msg_vld = 1'b0;
    msg_last = 1'b0;
    #1;
    chk("in_pad", pad_pkt, 1);
    @(negedge clk);
    #1;
    chk("in_zero", zero_pkt, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_outs", outs, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_clr", {clr, msg_rdy, st_pkt}, 3'b100);
    run_msg(1, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
